// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit retired per clock,
// start/done handshake, full 2*WIDTH-bit product held in p until the next
// accepted operation completes.
// Optional build macro SEQ_MULT_SIGNED_EN: treat a and b as two's complement
// (magnitudes are multiplied, the sign is applied on the final step).
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [2*WIDTH-1:0] p_r, p_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] result_s;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_r, neg_s;

  // Magnitude of a two's complement value; the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (x[WIDTH-1]) begin
      r = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction
`endif

  // One shift-add step: the adder is WIDTH+1 wide so its carry shifts into the top.
  always_comb begin
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
               + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
    if (neg_r) begin
      result_s = (~acc_step_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = acc_step_s;
    end
`else
    result_s   = acc_step_s;
`endif
  end

  // Next-state and next-register logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mcand_s = mcand_r;
    acc_s   = acc_r;
    p_s     = p_r;
    done_s  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    neg_s   = neg_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef SEQ_MULT_SIGNED_EN
          mcand_s = abs_f(a);
          acc_s   = {{WIDTH{1'b0}}, abs_f(b)};
          neg_s   = a[WIDTH-1] ^ b[WIDTH-1];
`else
          mcand_s = a;
          acc_s   = {{WIDTH{1'b0}}, b};
`endif
          cnt_s   = {CW{1'b0}};
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_s = acc_step_s;
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CW'(WIDTH - 1)) begin
          p_s     = result_s;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and datapath registers; rst overrides everything, aborting any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mcand_r <= mcand_s;
      acc_r   <= acc_s;
      p_r     <= p_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef SEQ_MULT_SIGNED_EN
      neg_r   <= neg_s;
`endif
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = p_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=8). A cycle-level model
// decides which starts are accepted and pushes the expected product and done
// cycle; a negedge monitor compares busy, done and p every cycle.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_until = -1;
  logic [2*W-1:0] hold_exp = '0;
  logic [2*W-1:0] exp_p_q[$];
  int             exp_cyc_q[$];

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint r;
`ifdef SEQ_MULT_SIGNED_EN
    r = longint'($signed(x)) * longint'($signed(y));
`else
    r = longint'(x) * longint'(y);
`endif
    return r[2*W-1:0];
  endfunction

  // Reference model: decide acceptance from the spec's schedule, push expectations.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      busy_until = -1;
      hold_exp   = '0;
      exp_p_q.delete();
      exp_cyc_q.delete();
    end else if (start && (cyc - 1 > busy_until)) begin
      busy_until = cyc + W;
      exp_p_q.push_back(ref_mul(a, b));
      exp_cyc_q.push_back(cyc + W);
    end
  end

  // Monitor: compare DUT outputs against the model between clock edges.
  always @(negedge clk) begin
    logic exp_done;
    exp_done = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    chk("busy", {63'd0, busy}, {63'd0, (cyc <= busy_until)});
    chk("done", {63'd0, done}, {63'd0, exp_done});
    if (exp_done) begin
      hold_exp = exp_p_q.pop_front();
      void'(exp_cyc_q.pop_front());
      chk("product", {48'd0, p}, {48'd0, hold_exp});
    end else begin
      chk("p_hold", {48'd0, p}, {48'd0, hold_exp});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for idle, then issue a one-cycle start.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      step(1);
      guard++;
    end
    chk("idle_wait_timeout", {63'd0, (guard >= 50)}, 64'd0);
    a = x;
    b = y;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step(3);
    rst = 1'b0;
    step(2);

    // Directed values, including boundaries and signed-mode corner cases.
    op(8'd13, 8'd11);
    op(8'd255, 8'd255);
    op(8'd0, 8'd200);
    op(8'd200, 8'd0);
    op(8'hFD, 8'd5);
    op(8'h80, 8'h80);
    op(8'h7F, 8'hFF);

    // Second start while busy must be ignored.
    op(8'd7, 8'd9);
    step(1);
    a = 8'd100; b = 8'd100; start = 1'b1;
    step(1);
    start = 1'b0;
    step(W + 2);

    // Reset mid-operation aborts with no done pulse.
    op(8'd50, 8'd50);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(W + 3);
    op(8'd3, 8'd4);

    // Continuous start: one result every W+2 cycles.
    step(W + 2);
    a = 8'd2; b = 8'd3; start = 1'b1;
    step(4 * (W + 2));
    start = 1'b0;

    // Random operations with occasional ignored starts and aborts.
    for (int i = 0; i < 40; i++) begin
      op(W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(0, W - 2));
        a = W'($urandom); b = W'($urandom); start = 1'b1;
        step(1);
        start = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        step($urandom_range(0, W));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(0, 3));
    end

    step(W + 4);
    chk("pending_results", 64'(exp_p_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
